// File: rtl/ntt_pkg.sv
// ntt_pkg: shared FSM state type and bit-reversal helper for the NTT read path
package ntt_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = x[w-1-i];
        return r;
    endfunction
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry register FIFO holding words returned by the RAM
//   clk, reset : clock, async active-high reset
//   push, din  : write a word
//   pop        : remove the head word (caller only pops when count != 0)
//   count      : occupancy 0..2
//   head       : oldest word (slot 0)
module skid_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] m1;
    logic [1:0]   wslot;
    // an incoming word lands in the slot left free after this cycle's pop
    assign wslot = count - {1'b0, pop};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            head  <= '0;
            m1    <= '0;
            count <= '0;
        end else begin
            if (pop) head <= m1;
            if (push && wslot == 2'd0) head <= din;
            if (push && wslot == 2'd1) m1 <= din;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: issues a run of RAM reads and streams the returned words
//   start/base/len : command, sampled in IDLE; len=0 completes with no reads
//   busy/done      : run in progress / one-cycle completion pulse
//   raddr/rdata    : RAM read port, data valid one cycle after raddr
//   m_valid/m_ready/m_data/m_last : output stream
//   brev           : bit-reversed read order, only with BRAM_RD_BITREV_EN
module bram_stream_reader
    import ntt_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int MSIZE = 1024,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DEPTH-1:0] base,
    input  logic [DEPTH:0]   len,
`ifdef BRAM_RD_BITREV_EN
    input  logic             brev,
`endif
    output logic             busy,
    output logic             done,
    output logic [DEPTH-1:0] raddr,
    input  logic [DSIZE-1:0] rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last
);
    localparam logic [DEPTH-1:0] AMASK = DEPTH'(MSIZE - 1);
    state_t state, nxt;
    logic [DEPTH-1:0] base_q, raddr_q, off, addr;
    logic [DEPTH:0]   len_q, idx;
    logic [1:0]       cnt;
    logic [DSIZE:0]   head;
    logic             inflight, inflight_last, issue, pop, last_rd, drained;
    assign pop = m_valid & m_ready;
    // words buffered plus the one in flight must leave room, counting a same-cycle pop
    assign issue = state == RUN && ({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    assign last_rd = issue && idx + 1'b1 == len_q;
`ifdef BRAM_RD_BITREV_EN
    logic brev_q;
    assign off = brev_q ? DEPTH'(bitrev(32'(idx[DEPTH-1:0]), DEPTH)) : idx[DEPTH-1:0];
    always_ff @(posedge clk or posedge reset)
        if (reset) brev_q <= 1'b0;
        else if (state == IDLE && start) brev_q <= brev;
`else
    assign off = idx[DEPTH-1:0];
`endif
    assign addr = (base_q + off) & AMASK;
    assign raddr = issue ? addr : raddr_q;
    always_comb begin
        drained = cnt == 2'd0 && !inflight;
        nxt = state == IDLE ? (start ? (len == '0 ? DRAIN : RUN) : IDLE)
            : state == RUN ? (last_rd ? DRAIN : RUN)
            : (drained ? IDLE : DRAIN);
        busy = state == RUN || (state == DRAIN && !drained);
        done = state == DRAIN && drained;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state         <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            idx           <= '0;
            raddr_q       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= nxt;
            inflight      <= issue;
            inflight_last <= last_rd;
            if (issue) begin
                raddr_q <= addr;
                idx     <= idx + 1'b1;
            end
            if (state == IDLE && start) begin
                base_q <= base;
                len_q  <= len;
                idx    <= '0;
            end
        end
    // the last-word flag travels with its data through the buffer
    skid_fifo2 #(.W(DSIZE + 1)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   ({inflight_last, rdata}),
        .count (cnt),
        .head  (head)
    );
    assign m_valid = cnt != 2'd0;
    assign m_data  = head[DSIZE-1:0];
    assign m_last  = m_valid & head[DSIZE];
endmodule
